// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// the fetch-fairness limit on back-to-back data grants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

  localparam int GRANT_LIMIT = 3;
  localparam int GRANT_CNT_W = 2;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts busy cycles without an acknowledge; expired flags the last cycle
// the arbiter may wait before declaring the memory unresponsive.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] count;

  // Holds at the expiry value so the count can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single shared memory port between instruction fetch and the
// data (load/store) stage, with fetch-fairness, stall requests and a timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRData,
  output logic              IValid,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic [DATA_W-1:0] DRData,
  output logic              DValid,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck,
  output logic              StallFReq,
  output logic              StallMReq,
  output logic              MemErr
);

  arb_state_t             state;
  logic [GRANT_CNT_W-1:0] grant_cnt;
  logic                   acc_we;
  logic [ADDR_W-1:0]      acc_addr;
  logic [DATA_W-1:0]      acc_wdata;

  logic busy;
  logic grant;
  logic fetch_wins;
  logic timed_out;

  assign busy       = (state == DBUSY) || (state == IBUSY);
  assign grant      = (state == IDLE) && (DReq || IReq);
  assign fetch_wins = IReq && (!DReq || (grant_cnt == GRANT_CNT_W'(GRANT_LIMIT)));

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant),
    .enable (busy && !MemAck),
    .expired(timed_out)
  );

  // grant_cnt only grows while fetch is being passed over; any other grant resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_cnt <= '0;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            if (fetch_wins) begin
              state     <= IBUSY;
              acc_we    <= 1'b0;
              acc_addr  <= IAddr;
              acc_wdata <= '0;
              grant_cnt <= '0;
            end else begin
              state     <= DBUSY;
              acc_we    <= DWe;
              acc_addr  <= DAddr;
              acc_wdata <= DWData;
              if (!IReq) begin
                grant_cnt <= '0;
              end else if (grant_cnt != GRANT_CNT_W'(GRANT_LIMIT)) begin
                grant_cnt <= grant_cnt + 1'b1;
              end
            end
          end
        end
        DBUSY, IBUSY: begin
          if (MemAck) begin
            state <= IDLE;
          end else if (timed_out) begin
            state <= ERR;
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  assign MemReq   = busy;
  assign MemWe    = busy && acc_we;
  assign MemAddr  = busy ? acc_addr : '0;
  assign MemWData = busy ? acc_wdata : '0;
  assign MemErr   = (state == ERR);

  assign DValid = (state == DBUSY) && MemAck;
  assign IValid = (state == IBUSY) && MemAck;
  assign DRData = (DValid && !acc_we) ? MemRData : '0;
  assign IRData = IValid ? MemRData : '0;

  // Stalls are masked during reset so every output reads zero while rst is high.
  assign StallMReq = !rst && ((state == ERR) || (DReq && !DValid));
  assign StallFReq = !rst && ((state == ERR) || (IReq && !IValid) || (DReq && !DValid));

endmodule
